// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
//   mem_state_t  : responder FSM states (IDLE, WAIT, RESP)
//   mem_req_t    : request captured when a transaction is accepted
//   lane_enables : byte-lane write-enable decode from byte_op and address[1:0]
package mem_pkg;

    localparam int DATA_W     = 32;
    localparam int BYTE_LANES = 4;
    localparam int LANE_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic              byte_op;
    } mem_req_t;

    // Word accesses enable every lane; byte accesses enable only the
    // addressed lane (little-endian, lane 0 = bits [7:0]).
    function automatic logic [BYTE_LANES-1:0] lane_enables(
        input logic       byte_op,
        input logic [1:0] lane
    );
        logic [BYTE_LANES-1:0] en;
        en = byte_op ? (BYTE_LANES'(1) << lane) : '1;
        return en;
    endfunction

endpackage

// File: rtl/mem_lane_ram.sv
// Single-port word array with per-byte-lane write enables and a registered
// read port.
//   clk      in   1                  clock
//   index    in   INDEX_BITS         word index
//   lane_we  in   BYTE_LANES         per-lane write enables
//   wdata    in   BYTE_LANES x 8     write data, one byte per lane
//   re       in   1                  read enable; rdata updates only when set
//   rdata    out  BYTE_LANES x 8     registered read data, held between reads
module mem_lane_ram
    import mem_pkg::*;
#(
    parameter int INDEX_BITS = 10
) (
    input  logic                                 clk,
    input  logic [INDEX_BITS-1:0]                index,
    input  logic [BYTE_LANES-1:0]                lane_we,
    input  logic [BYTE_LANES-1:0][LANE_W-1:0]    wdata,
    input  logic                                 re,
    output logic [BYTE_LANES-1:0][LANE_W-1:0]    rdata
);

    localparam int DEPTH = 2 ** INDEX_BITS;

    logic [BYTE_LANES-1:0][LANE_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; clearing it would prevent
    // mapping onto block RAM, and the contents are defined only by writes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (lane_we[i]) begin
                mem[index][i] <= wdata[i];
            end
        end
        if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder at the far end of the cache's mem_* port bundle.
// Accepts one request at a time, waits a fixed LATENCY, performs a word or
// byte access on an internal array, then pulses ack_o for one cycle.
//   clk_i               in   1      clock
//   rst_i               in   1      synchronous active-high reset
//   req_i               in   1      request valid, held with mem_* until ack_o
//   mem_address_i       in   WIDTH  byte address (bits above ADDR_BITS alias)
//   mem_write_data_i    in   WIDTH  write data; byte writes use bits [7:0]
//   mem_write_enable_i  in   1      1 = write, 0 = read
//   mem_byte_op_i       in   1      1 = byte access, 0 = word access
//   mem_read_data_o     out  WIDTH  read data, valid with ack_o, held afterwards
//   ack_o               out  1      one-cycle completion pulse
//   busy_o              out  1      request outstanding (WAIT or RESP)
//   err_o               out  1      with ack_o: misaligned word access, no access made
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [WIDTH-1:0] mem_address_i,
    input  logic [WIDTH-1:0] mem_write_data_i,
    input  logic             mem_write_enable_i,
    input  logic             mem_byte_op_i,
    output logic [WIDTH-1:0] mem_read_data_o,
    output logic             ack_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int INDEX_BITS = ADDR_BITS - 2;
    localparam int CNT_W      = 4;

    mem_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    mem_req_t                req_q, req_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [DATA_W-1:0]       resp_data;
    logic [BYTE_LANES-1:0]   access_we;
    logic [BYTE_LANES-1:0]   lane_we;
    logic                    ram_re;
    logic [BYTE_LANES-1:0][LANE_W-1:0] ram_wdata;
    logic [BYTE_LANES-1:0][LANE_W-1:0] ram_rdata;

    // Address bits above ADDR_BITS are deliberately ignored (aliasing).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_q.addr[DATA_W-1:ADDR_BITS];

    // NOTE: all state is updated with non-blocking assignments in a single
    // clocked process; everything combinational lives in always_comb with
    // defaults assigned first so no latches are inferred.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // Byte writes replicate the byte onto every lane; the lane enables pick
    // which one actually lands.
    assign ram_wdata = req_q.byte_op ? {BYTE_LANES{req_q.wdata[LANE_W-1:0]}}
                                     : req_q.wdata;

    // A reset arriving on the access cycle must not let the write through.
    assign lane_we = rst_i ? '0 : access_we;

    mem_lane_ram #(
        .INDEX_BITS (INDEX_BITS)
    ) u_ram (
        .clk     (clk_i),
        .index   (req_q.addr[ADDR_BITS-1:2]),
        .lane_we (lane_we),
        .wdata   (ram_wdata),
        .re      (ram_re),
        .rdata   (ram_rdata)
    );

    // Value presented during RESP: zero on error, fresh read data on reads,
    // previous response data on writes.
    always_comb begin
        resp_data = data_q;
        if (err_q) begin
            resp_data = '0;
        end else if (!req_q.we) begin
            resp_data = req_q.byte_op
                ? {{(DATA_W-LANE_W){1'b0}}, ram_rdata[req_q.addr[1:0]]}
                : ram_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        err_d     = err_q;
        data_d    = data_q;
        access_we = '0;
        ram_re    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    req_d.addr    = mem_address_i;
                    req_d.wdata   = mem_write_data_i;
                    req_d.we      = mem_write_enable_i;
                    req_d.byte_op = mem_byte_op_i;
                    if (!mem_byte_op_i && (mem_address_i[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RESP;
                    if (req_q.we) begin
                        access_we = lane_enables(req_q.byte_op, req_q.addr[1:0]);
                    end else begin
                        ram_re = 1'b1;
                    end
                end
            end
            RESP: begin
                data_d  = resp_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_o           = (state_q == RESP);
        busy_o          = (state_q != IDLE);
        err_o           = (state_q == RESP) && err_q;
        mem_read_data_o = (state_q == RESP) ? resp_data : data_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a table of single transactions on a
// LATENCY=2 instance, hand-written sequences for held/changing requests and
// reset abort, and a LATENCY=1 instance for the short-latency timing.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        req, we, byte_op;
    logic [31:0] addr, wdata, rdata;
    logic        ack, busy, err;

    logic        req1, we1, byte1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        ack1, busy1, err1;

    data_mem_responder #(.WIDTH(32), .ADDR_BITS(12), .LATENCY(LAT)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_i              (req),
        .mem_address_i      (addr),
        .mem_write_data_i   (wdata),
        .mem_write_enable_i (we),
        .mem_byte_op_i      (byte_op),
        .mem_read_data_o    (rdata),
        .ack_o              (ack),
        .busy_o             (busy),
        .err_o              (err)
    );

    data_mem_responder #(.WIDTH(32), .ADDR_BITS(12), .LATENCY(1)) dut_l1 (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_i              (req1),
        .mem_address_i      (addr1),
        .mem_write_data_i   (wdata1),
        .mem_write_enable_i (we1),
        .mem_byte_op_i      (byte1),
        .mem_read_data_o    (rdata1),
        .ack_o              (ack1),
        .busy_o             (busy1),
        .err_o              (err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        byte_op;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        int          accept_cyc;
        int          delta;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive a request and record what its response must look like. The ack
    // cycle number counts posedges up to the end of the ack cycle, so a
    // normal access expects LAT+1 and a misaligned one expects 1.
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic b, input logic [31:0] ed,
                         input logic ee, input int accept_at);
        sb_t e;
        req     = 1'b1;
        addr    = a;
        wdata   = d;
        we      = w;
        byte_op = b;
        e.name       = name;
        e.data       = ed;
        e.err        = ee;
        e.accept_cyc = accept_at;
        e.delta      = ee ? 1 : LAT + 1;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: no ack_o within 40 cycles", name);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        @(negedge clk);
        issue(name, v.addr, v.wdata, v.we, v.byte_op, v.exp_data, v.exp_err, cyc + 1);
        wait_ack(name);
        req = 1'b0;
    endtask

    task automatic l1_txn(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic b, input logic [31:0] ed);
        int          busy_cnt;
        int          ack_at;
        int          accept_at;
        logic [31:0] got;
        busy_cnt = 0;
        ack_at   = -1;
        got      = '0;
        @(negedge clk);
        req1 = 1'b1; addr1 = a; wdata1 = d; we1 = w; byte1 = b;
        accept_at = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy1) busy_cnt++;
            if (ack1 && ack_at < 0) begin
                ack_at = cyc;
                got    = rdata1;
                req1   = 1'b0;
            end
        end
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd2);
        check({name, "_latency"}, 32'(ack_at - accept_at + 1), 32'd2);
        check({name, "_data"}, got, ed);
    endtask

    // Scoreboard: every ack_o pops the oldest expected response.
    always @(negedge clk) begin
        if (ack) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: ack_o=1 at cycle %0d, expected no ack", cyc);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, rdata, e.data);
                check({e.name, "_err"}, 32'(err), 32'(e.err));
                check({e.name, "_latency"}, 32'(cyc - e.accept_cyc + 1), 32'(e.delta));
            end
        end
    end

    initial begin
        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{32'h0000_0010, 32'h1122_3344, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{32'h0000_0013, 32'hFFFF_FFAA, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hAA22_3344, 1'b0};
        vecs[5]  = '{32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'h0000_00AA, 1'b0};
        vecs[6]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'h0000_0044, 1'b0};
        vecs[7]  = '{32'h0000_0012, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[8]  = '{32'h0000_0011, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hAA22_3344, 1'b0};
        vecs[10] = '{32'h0000_0000, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hAA22_3344, 1'b0};
        vecs[11] = '{32'h0000_1000, 32'h0,         1'b0, 1'b0, 32'hCAFE_F00D, 1'b0};
        vecs[12] = '{32'h0000_0001, 32'h0000_005A, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{32'hFFFF_F000, 32'h0,         1'b0, 1'b0, 32'hCAFE_5A0D, 1'b0};
        vecs[14] = '{32'h0000_1001, 32'h0,         1'b0, 1'b1, 32'h0000_005A, 1'b0};
        vecs[15] = '{32'h0000_0020, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_005A, 1'b0};
        vecs[16] = '{32'h0000_0FFC, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0000_005A, 1'b0};
        vecs[17] = '{32'h0000_0FFF, 32'h0,         1'b0, 1'b1, 32'h0000_000B, 1'b0};
        vecs[18] = '{32'h0000_0FFC, 32'h0,         1'b0, 1'b0, 32'h0BAD_F00D, 1'b0};
        vecs[19] = '{32'h0000_0012, 32'h0,         1'b0, 1'b1, 32'h0000_0022, 1'b0};

        rst = 1'b1;
        req = 1'b0; addr = '0; wdata = '0; we = 1'b0; byte_op = 1'b0;
        req1 = 1'b0; addr1 = '0; wdata1 = '0; we1 = 1'b0; byte1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_data", rdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Request fields change (and req drops) while WAIT: latched request wins.
        @(negedge clk);
        issue("ignore_change", 32'h10, 32'h0, 1'b0, 1'b0, 32'hAA22_3344, 1'b0, cyc + 1);
        @(negedge clk);
        req = 1'b0; addr = 32'h0; byte_op = 1'b1;
        wait_ack("ignore_change");

        // req held through RESP with the next request: accepted only after one IDLE cycle.
        @(negedge clk);
        issue("held_first", 32'h0, 32'h0, 1'b0, 1'b0, 32'hCAFE_5A0D, 1'b0, cyc + 1);
        wait_ack("held_first");
        issue("held_second", 32'h1003, 32'h0, 1'b0, 1'b1, 32'h0000_00CA, 1'b0, cyc + 2);
        @(negedge clk);
        check("held_idle_gap_busy", 32'(busy), 32'd0);
        wait_ack("held_second");
        req = 1'b0;

        // Reset sampled on the very edge the write of 0x55 @0x20 would land.
        @(negedge clk);
        req = 1'b1; addr = 32'h20; wdata = 32'h55; we = 1'b1; byte_op = 1'b0;
        @(negedge clk);
        check("abort_wait_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_data", rdata, 32'h0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        issue("abort_readback", 32'h20, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, cyc + 1);
        wait_ack("abort_readback");
        req = 1'b0;
        @(negedge clk);

        // LATENCY=1 instance.
        l1_txn("l1_write", 32'h40, 32'h7654_3210, 1'b1, 1'b0, 32'h0);
        l1_txn("l1_read", 32'h40, 32'h0, 1'b0, 1'b0, 32'h7654_3210);
        l1_txn("l1_byte_read", 32'h42, 32'h0, 1'b0, 1'b1, 32'h0000_0054);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
